note_judge: RTL

Per-beat note judgement and scoring engine for the guitar game. It takes the chart note for the current beat, the scroll position within the beat, the fret keys and the strum input, then decides hit, miss or ghost strum and maintains the streak, multiplier, points and miss counters. It sits between the controller/song-data side and the VGA and LED display logic. It generalises the original hard-wired 5-lane, fixed-window, fixed-tier scoring to a parametrised lane count, timing window and tier set, and adds explicit miss reporting, ghost-strum handling and hit history.

---
 rtl/note_judge_pkg.sv | 25 ++
 rtl/edge_detect.sv | 23 ++
 rtl/note_judge.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/note_judge_pkg.sv
// Shared types and multiplier rules for the note judgement engine.
package note_judge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    WINDOW,
    DONE
  } judge_state_t;

  localparam logic [2:0] MULT_X1 = 3'd1;
  localparam logic [2:0] MULT_X2 = 3'd2;
  localparam logic [2:0] MULT_X3 = 3'd3;
  localparam logic [2:0] MULT_X4 = 3'd4;

  // Multiplier tier for a given streak; the top tier is only reached at saturation.
  function automatic logic [2:0] mult_of(input int streak, input int smax = 15,
                                         input int tier1 = 5, input int tier2 = 10);
    if (streak == smax)       return MULT_X4;
    else if (streak >= tier2) return MULT_X3;
    else if (streak >= tier1) return MULT_X2;
    else                      return MULT_X1;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Two-flop synchroniser with a single-cycle rising-edge strobe for controller buttons.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic s1, s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;

endmodule

// File: rtl/note_judge.sv
// Per-beat note judgement: decides hit / miss / ghost strum and keeps streak, score and miss tallies.
module note_judge
  import note_judge_pkg::*;
#(
  parameter int LANES      = 5,
  parameter int POS_W      = 9,
  parameter int WIN_LO     = 8,
  parameter int WIN_HI     = 56,
  parameter int STREAK_MAX = 15,
  parameter int TIER1      = 5,
  parameter int TIER2      = 10,
  parameter int PTS_W      = 13,
  parameter int MISS_W     = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic                              clear,
  input  logic                              beat_tick,
  input  logic [LANES-1:0]                  note_mask,
  input  logic [POS_W-1:0]                  pos,
  input  logic [LANES-1:0]                  keys,
  input  logic                              strum_raw,
  output logic [$clog2(STREAK_MAX+1)-1:0]   streak,
  output logic [2:0]                        mult,
  output logic [PTS_W-1:0]                  points,
  output logic [MISS_W-1:0]                 misses,
  output logic                              hit_pulse,
  output logic                              miss_pulse,
  output logic                              ghost_pulse,
  output logic [1:0]                        hit_hist
);

  localparam int SW = $clog2(STREAK_MAX + 1);

  function automatic logic [PTS_W-1:0] sat_add_pts(input logic [PTS_W-1:0] a,
                                                   input logic [2:0] b);
    logic [PTS_W:0] sum;
    sum = {1'b0, a} + (PTS_W+1)'(b);
    return sum[PTS_W] ? '1 : sum[PTS_W-1:0];
  endfunction

  function automatic logic [MISS_W-1:0] sat_inc_miss(input logic [MISS_W-1:0] a);
    return (a == '1) ? a : a + MISS_W'(1);
  endfunction

  function automatic logic [SW-1:0] sat_inc_streak(input logic [SW-1:0] a);
    return (a == SW'(STREAK_MAX)) ? a : a + SW'(1);
  endfunction

  judge_state_t     state_q, state_d, st_c;
  logic [LANES-1:0] mask_q, mask_d;
  logic [SW-1:0]    streak_d;
  logic [PTS_W-1:0] points_d;
  logic [MISS_W-1:0] misses_d;
  logic [1:0]       hist_d;
  logic             hit_c, miss_c, ghost_c;
  logic             strum_ev;

  edge_detect u_strum (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (strum_raw),
    .rise  (strum_ev)
  );

  assign mult = mult_of(int'(streak), STREAK_MAX, TIER1, TIER2);

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    streak_d = streak;
    points_d = points;
    misses_d = misses;
    hist_d   = hit_hist;
    st_c     = state_q;
    hit_c    = 1'b0;
    miss_c   = 1'b0;
    ghost_c  = 1'b0;

    if (clear) begin
      state_d  = IDLE;
      mask_d   = '0;
      streak_d = '0;
      points_d = '0;
      misses_d = '0;
      hist_d   = '0;
    end else if (!enable) begin
      state_d = IDLE;
    end else begin
      // The outgoing note is closed before anything is judged against the new one.
      if (beat_tick) begin
        hist_d = {hit_hist[0], 1'b0};
        if (st_c == ARMED || st_c == WINDOW) miss_c = 1'b1;
        st_c   = (note_mask != '0) ? ARMED : IDLE;
        mask_d = note_mask;
      end
      if (st_c == ARMED && pos == POS_W'(WIN_LO)) st_c = WINDOW;
      if (st_c == WINDOW) begin
        if (strum_ev && keys == mask_d) begin
          hit_c = 1'b1;
          st_c  = DONE;
        end else if (pos == POS_W'(WIN_HI)) begin
          miss_c = 1'b1;
          st_c   = DONE;
        end
      end
      // A miss already zeroes the streak; reporting one event keeps the strobes exclusive.
      ghost_c = strum_ev & ~hit_c & ~miss_c;
      state_d = st_c;

      if (hit_c) begin
        hist_d[0] = 1'b1;
        points_d  = sat_add_pts(points, mult);
        streak_d  = sat_inc_streak(streak);
      end
      if (miss_c || ghost_c) streak_d = '0;
      if (miss_c) misses_d = sat_inc_miss(misses);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      streak      <= '0;
      points      <= '0;
      misses      <= '0;
      hit_hist    <= '0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      ghost_pulse <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      streak      <= streak_d;
      points      <= points_d;
      misses      <= misses_d;
      hit_hist    <= hist_d;
      hit_pulse   <= hit_c;
      miss_pulse  <= miss_c;
      ghost_pulse <= ghost_c;
    end
  end

endmodule
